// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed data memory with valid/ready handshake, wait states and error detection
// Ports: clk, rst_n (async active-low); request req_valid/req_ready/req_we/req_addr/req_len/req_unsigned/req_wdata;
// response resp_valid/resp_ready/resp_rdata/resp_err. Optional macro DMEM_PERF_CNT_EN adds rd_cnt/wr_cnt/err_cnt.
module dmem_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_len,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [31:0]           rd_cnt,
  output logic [31:0]           wr_cnt,
  output logic [31:0]           err_cnt
`endif
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int MAW = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                state;
  logic [7:0]            mem [MEM_DEPTH];
  logic                  we_q, uns_q;
  logic [MAW-1:0]        addr_q;
  logic [1:0]            len_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            cnt;
  logic                  idle, accept, req_err, access, we_s, uns_s, sbit;
  logic [MAW-1:0]        a_s;
  logic [1:0]            len_s;
  logic [DATA_WIDTH-1:0] wd_s, raw, ld;
  int                    nb;
  assign idle   = state == IDLE;
  assign accept = idle & req_valid & req_ready;
  // The access uses live inputs on the accept edge and latched fields from WAIT.
  assign a_s    = idle ? req_addr[MAW-1:0] : addr_q;
  assign len_s  = idle ? req_len : len_q;
  assign we_s   = idle ? req_we : we_q;
  assign uns_s  = idle ? req_unsigned : uns_q;
  assign wd_s   = idle ? req_wdata : wdata_q;
  // Aligned accesses below MEM_DEPTH never straddle the end of memory.
  assign req_err = (|(req_addr >> MAW)) |
                   (req_len == 2'd3 && DATA_WIDTH == 32) |
                   (req_len == 2'd1 && req_addr[0]) |
                   (req_len == 2'd2 && |req_addr[1:0]) |
                   (req_len == 2'd3 && |req_addr[2:0]);
  assign access = (accept & ~req_err & (WAIT_STATES == 0)) | (state == WAIT && cnt == 4'd0);
  always_comb begin
    nb  = 1 << len_s;
    raw = '0;
    ld  = '0;
    for (int i = 0; i < NB; i++) raw[8*i +: 8] = mem[a_s + MAW'(i)];
    sbit = len_s == 2'd0 ? raw[7] : len_s == 2'd1 ? raw[15] : len_s == 2'd2 ? raw[31] : raw[DATA_WIDTH-1];
    for (int i = 0; i < DATA_WIDTH; i++) ld[i] = (i < 8 * nb) ? raw[i] : (~uns_s & sbit);
  end
  always_ff @(posedge clk)
    if (access && we_s)
      for (int i = 0; i < NB; i++)
        if (i < nb) mem[a_s + MAW'(i)] <= wd_s[8*i +: 8];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      addr_q     <= '0;
      len_q      <= 2'd0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= ~accept;
          if (accept) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr[MAW-1:0];
            len_q   <= req_len;
            wdata_q <= req_wdata;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (WAIT_STATES == 0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= req_we ? '0 : ld;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= we_q ? '0 : ld;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      err_cnt <= '0;
    end else if (resp_valid && resp_ready) begin
      if (resp_err) begin
        if (~&err_cnt) err_cnt <= err_cnt + 32'd1;
      end else if (we_q) begin
        if (~&wr_cnt) wr_cnt <= wr_cnt + 32'd1;
      end else begin
        if (~&rd_cnt) rd_cnt <= rd_cnt + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: table-driven scoreboard bench for dmem_ctrl with WAIT_STATES=0 and WAIT_STATES=3 instances
module tb_dmem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        we, uns, v0, v3, rr0, rr3, s;
  logic [31:0] addr, wdata;
  logic [1:0]  len;
  logic        rdy0, rdy3, rv0, rv3, e0, e3;
  logic [31:0] d0, d3;
`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rc0, wc0, ec0, rc3, wc3, ec3;
`endif
  dmem_ctrl #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rdy0), .req_we(we), .req_addr(addr),
    .req_len(len), .req_unsigned(uns), .req_wdata(wdata), .resp_valid(rv0), .resp_ready(rr0),
    .resp_rdata(d0), .resp_err(e0)
`ifdef DMEM_PERF_CNT_EN
    , .rd_cnt(rc0), .wr_cnt(wc0), .err_cnt(ec0)
`endif
  );
  dmem_ctrl #(.WAIT_STATES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3), .req_we(we), .req_addr(addr),
    .req_len(len), .req_unsigned(uns), .req_wdata(wdata), .resp_valid(rv3), .resp_ready(rr3),
    .resp_rdata(d3), .resp_err(e3)
`ifdef DMEM_PERF_CNT_EN
    , .rd_cnt(rc3), .wr_cnt(wc3), .err_cnt(ec3)
`endif
  );
  logic        rdy, rv, e;
  logic [31:0] d;
  assign rdy = s ? rdy3 : rdy0;
  assign rv  = s ? rv3 : rv0;
  assign e   = s ? e3 : e0;
  assign d   = s ? d3 : d0;
  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;
  typedef struct {
    logic        s;
    logic        we;
    logic [31:0] a;
    logic [1:0]  l;
    logic        u;
    logic [31:0] wd;
    logic [31:0] ed;
    logic        ee;
  } vec_t;
  exp_t q[$];
  vec_t vt[25];
  int tests = 0;
  int fails = 0;
  int mrd[2], mwr[2], mer[2];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic xfer(input logic sel, input logic w, input logic [31:0] a, input logic [1:0] l,
                      input logic u, input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                      input int hold, input string nm);
    exp_t x;
    int   n;
    @(negedge clk);
    s = sel; we = w; addr = a; len = l; uns = u; wdata = wd;
    if (sel) v3 = 1'b1; else v0 = 1'b1;
    q.push_back('{ed, ee});
    n = 0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      chk({nm, "/ready_timeout"}, 32'(rdy), 32'd1);
      v0 = 1'b0; v3 = 1'b0;
      void'(q.pop_back());
      return;
    end
    @(posedge clk);
    #1;
    v0 = 1'b0; v3 = 1'b0;
    we = 1'($urandom); addr = $urandom; len = 2'($urandom); uns = 1'($urandom); wdata = $urandom;
    n = 1;
    @(negedge clk);
    while (!rv && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "/latency"}, 32'(n), sel ? 32'd4 : 32'd1);
    x = q.pop_front();
    chk({nm, "/rdata"}, d, x.d);
    chk({nm, "/err"}, 32'(e), 32'(x.e));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "/hold_valid"}, 32'(rv), 32'd1);
      chk({nm, "/hold_rdata"}, d, x.d);
      chk({nm, "/hold_ready"}, 32'(rdy), 32'd0);
    end
    if (rv) begin
      if (x.e) mer[sel]++; else if (w) mwr[sel]++; else mrd[sel]++;
    end
    if (sel) rr3 = 1'b1; else rr0 = 1'b1;
    @(posedge clk);
    #1;
    rr0 = 1'b0; rr3 = 1'b0;
    chk({nm, "/drained"}, 32'(rv), 32'd0);
    chk({nm, "/ready_again"}, 32'(rdy), 32'd1);
  endtask
  initial begin
    vt = '{
      '{1'b0, 1'b1, 32'h000, 2'd2, 1'b0, 32'h12345678, 32'h00000000, 1'b0},
      '{1'b0, 1'b0, 32'h000, 2'd2, 1'b0, 32'h0,        32'h12345678, 1'b0},
      '{1'b0, 1'b1, 32'h004, 2'd2, 1'b0, 32'h00000000, 32'h00000000, 1'b0},
      '{1'b0, 1'b1, 32'h005, 2'd0, 1'b0, 32'h000000AB, 32'h00000000, 1'b0},
      '{1'b0, 1'b0, 32'h005, 2'd0, 1'b0, 32'h0,        32'hFFFFFFAB, 1'b0},
      '{1'b0, 1'b0, 32'h005, 2'd0, 1'b1, 32'h0,        32'h000000AB, 1'b0},
      '{1'b0, 1'b0, 32'h004, 2'd2, 1'b0, 32'h0,        32'h0000AB00, 1'b0},
      '{1'b0, 1'b0, 32'h003, 2'd1, 1'b0, 32'h0,        32'h00000000, 1'b1},
      '{1'b0, 1'b1, 32'h402, 2'd2, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1},
      '{1'b0, 1'b0, 32'h000, 2'd2, 1'b0, 32'h0,        32'h12345678, 1'b0},
      '{1'b0, 1'b0, 32'h008, 2'd3, 1'b0, 32'h0,        32'h00000000, 1'b1},
      '{1'b0, 1'b1, 32'h006, 2'd1, 1'b0, 32'h1234BEEF, 32'h00000000, 1'b0},
      '{1'b0, 1'b0, 32'h004, 2'd2, 1'b0, 32'h0,        32'hBEEFAB00, 1'b0},
      '{1'b0, 1'b0, 32'h006, 2'd1, 1'b0, 32'h0,        32'hFFFFBEEF, 1'b0},
      '{1'b0, 1'b0, 32'h006, 2'd1, 1'b1, 32'h0,        32'h0000BEEF, 1'b0},
      '{1'b0, 1'b1, 32'h3FC, 2'd2, 1'b0, 32'hA5A55A5A, 32'h00000000, 1'b0},
      '{1'b0, 1'b0, 32'h3FC, 2'd2, 1'b0, 32'h0,        32'hA5A55A5A, 1'b0},
      '{1'b0, 1'b0, 32'h400, 2'd0, 1'b0, 32'h0,        32'h00000000, 1'b1},
      '{1'b0, 1'b0, 32'h002, 2'd2, 1'b0, 32'h0,        32'h00000000, 1'b1},
      '{1'b0, 1'b1, 32'h002, 2'd1, 1'b0, 32'hFFFF7777, 32'h00000000, 1'b0},
      '{1'b0, 1'b0, 32'h000, 2'd2, 1'b0, 32'h0,        32'h77775678, 1'b0},
      '{1'b0, 1'b0, 32'h001, 2'd1, 1'b0, 32'h0,        32'h00000000, 1'b1},
      '{1'b1, 1'b1, 32'h008, 2'd2, 1'b0, 32'h11223344, 32'h00000000, 1'b0},
      '{1'b1, 1'b0, 32'h009, 2'd0, 1'b1, 32'h0,        32'h00000033, 1'b0},
      '{1'b1, 1'b0, 32'h00A, 2'd1, 1'b0, 32'h0,        32'h00001122, 1'b0}
    };
    we = 0; uns = 0; addr = 0; wdata = 0; len = 0; v0 = 0; v3 = 0; rr0 = 0; rr3 = 0; s = 0;
    mrd = '{0, 0}; mwr = '{0, 0}; mer = '{0, 0};
    repeat (2) @(negedge clk);
    chk("reset/ready", 32'(rdy0), 32'd0);
    chk("reset/valid", 32'(rv0), 32'd0);
    chk("reset/rdata", d0, 32'd0);
    chk("reset/err", 32'(e0), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset/ready0", 32'(rdy0), 32'd1);
    chk("post_reset/ready3", 32'(rdy3), 32'd1);
    for (int i = 0; i < 25; i++)
      xfer(vt[i].s, vt[i].we, vt[i].a, vt[i].l, vt[i].u, vt[i].wd, vt[i].ed, vt[i].ee, 0, $sformatf("vec%0d", i));
    xfer(1'b1, 1'b0, 32'h008, 2'd2, 1'b0, 32'h0, 32'h11223344, 1'b0, 5, "ws3_hold");
    @(negedge clk);
    s = 1'b1; we = 1'b1; addr = 32'h8; len = 2'd2; uns = 1'b0; wdata = 32'hDEADBEEF; v3 = 1'b1;
    chk("abort/ready", 32'(rdy3), 32'd1);
    @(posedge clk);
    #1;
    v3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort/valid", 32'(rv3), 32'd0);
    chk("abort/ready_low", 32'(rdy3), 32'd0);
    chk("abort/rdata", d3, 32'd0);
    chk("abort/err", 32'(e3), 32'd0);
    mrd = '{0, 0}; mwr = '{0, 0}; mer = '{0, 0};
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    xfer(1'b1, 1'b0, 32'h008, 2'd2, 1'b0, 32'h0, 32'h11223344, 1'b0, 0, "abort/reload");
    xfer(1'b0, 1'b0, 32'h004, 2'd2, 1'b0, 32'h0, 32'hBEEFAB00, 1'b0, 0, "after_reset/ws0");
    xfer(1'b0, 1'b1, 32'h010, 2'd0, 1'b0, 32'h0000005A, 32'h0, 1'b0, 0, "pc/store");
    xfer(1'b0, 1'b0, 32'h011, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 0, "pc/misaligned");
`ifdef DMEM_PERF_CNT_EN
    @(negedge clk);
    chk("perf/rd0", rc0, 32'(mrd[0]));
    chk("perf/wr0", wc0, 32'(mwr[0]));
    chk("perf/err0", ec0, 32'(mer[0]));
    chk("perf/rd3", rc3, 32'(mrd[1]));
    chk("perf/wr3", wc3, 32'(mwr[1]));
    chk("perf/err3", ec3, 32'(mer[1]));
    chk("perf/rd0_abs", rc0, 32'd1);
    chk("perf/wr0_abs", wc0, 32'd1);
    chk("perf/err0_abs", ec0, 32'd1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
